// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, load-size codes, FSM state codes and misalignment rule for the load/store unit.
package lsu_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  // size code 2'b11 is treated as a word access
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    return size[1] ? (a != 2'b00) : (size == LS_HALF) ? a[0] : 1'b0;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata_in,
  input  logic [1:0]      addr_in,
  input  logic [1:0]      size_in,
  input  logic            unsigned_in,
  output logic [XLEN-1:0] data_out
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata_in[{addr_in, 3'b000} +: 8];
    h = addr_in[1] ? rdata_in[31:16] : rdata_in[15:0];
    data_out = size_in[1] ? rdata_in :
               (size_in == LS_HALF) ? {{16{~unsigned_in & h[15]}}, h} :
               {{24{~unsigned_in & b[7]}}, b};
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: stage-3 data-memory access FSM with stall, lane alignment and misalignment flagging.
// Define LSU_TIMEOUT_EN to abort bus accesses that see no ready within TIMEOUT_CYCLES.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            ld_en_in,
  input  logic            st_en_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] st_data_in,
  input  logic [1:0]      load_size_in,
  input  logic            load_unsigned_in,
  input  logic [4:0]      rd_addr_in,
  output logic            dmem_req_out,
  output logic            dmem_we_out,
  output logic [XLEN-1:0] dmem_addr_out,
  output logic [XLEN-1:0] dmem_wdata_out,
  output logic [3:0]      dmem_mask_out,
  input  logic            dmem_ready_in,
  input  logic [XLEN-1:0] dmem_rdata_in,
  output logic            stall_out,
  output logic            load_valid_out,
  output logic [XLEN-1:0] load_data_out,
  output logic [4:0]      rd_addr_out,
  output logic            st_done_out,
  output logic            misaligned_out,
  output logic            bus_err_out
);
  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, data_q, data_d, load_data_q, load_data_d, aligned;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d, we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic            st_done_q, st_done_d, mis_q, mis_d, err_q, err_d;
  logic            req_any, mis, busy, timed_out;

  load_align u_align (
    .rdata_in   (dmem_rdata_in),
    .addr_in    (addr_q[1:0]),
    .size_in    (size_q),
    .unsigned_in(uns_q),
    .data_out   (aligned)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign timed_out = busy && !dmem_ready_in && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign cnt_d = busy ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  assign req_any = ld_en_in | st_en_in;
  assign mis = is_misaligned(load_size_in, addr_in[1:0]);
  assign busy = state_q == BUSY;

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    size_d = size_q;
    uns_d = uns_q;
    we_d = we_q;
    rd_d = rd_q;
    load_data_d = load_data_q;
    st_done_d = 1'b0;
    err_d = 1'b0;
    mis_d = (state_q == IDLE) && req_any && mis;
    if (state_q == IDLE && req_any && !mis) begin
      state_d = BUSY;
      addr_d = addr_in;
      data_d = st_data_in;
      size_d = load_size_in;
      uns_d = load_unsigned_in;
      we_d = ~ld_en_in;
      rd_d = rd_addr_in;
    end else if (busy && dmem_ready_in) begin
      state_d = we_q ? IDLE : DONE;
      st_done_d = we_q;
      load_data_d = we_q ? load_data_q : aligned;
    end else if (timed_out) begin
      state_d = IDLE;
      err_d = 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in)
    if (reset_in) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      we_q <= 1'b0;
      rd_q <= '0;
      load_data_q <= '0;
      st_done_q <= 1'b0;
      mis_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      size_q <= size_d;
      uns_q <= uns_d;
      we_q <= we_d;
      rd_q <= rd_d;
      load_data_q <= load_data_d;
      st_done_q <= st_done_d;
      mis_q <= mis_d;
      err_q <= err_d;
    end

  // bus fields are driven only while a transaction is outstanding
  always_comb begin
    dmem_req_out = busy;
    dmem_we_out = busy & we_q;
    dmem_addr_out = busy ? {addr_q[31:2], 2'b00} : '0;
    dmem_wdata_out = !(busy && we_q) ? '0 :
                     size_q[1] ? data_q :
                     (size_q == LS_HALF) ? {2{data_q[15:0]}} : {4{data_q[7:0]}};
    dmem_mask_out = !(busy && we_q) ? 4'b0000 :
                    size_q[1] ? 4'b1111 :
                    (size_q == LS_HALF) ? 4'b0011 << {addr_q[1], 1'b0} : 4'b0001 << addr_q[1:0];
    stall_out = busy || ((state_q == IDLE) && req_any && !mis);
    load_valid_out = state_q == DONE;
    load_data_out = load_data_q;
    rd_addr_out = rd_q;
    st_done_out = st_done_q;
    misaligned_out = mis_q;
    bus_err_out = err_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit (timeout scenario when LSU_TIMEOUT_EN is defined).
module tb_load_store_unit;
  logic        clk_in = 1'b0, reset_in = 1'b1;
  logic        ld_en_in = 0, st_en_in = 0, load_unsigned_in = 0, dmem_ready_in = 0;
  logic [31:0] addr_in = 0, st_data_in = 0, dmem_rdata_in = 0;
  logic [1:0]  load_size_in = 0;
  logic [4:0]  rd_addr_in = 0;
  logic        dmem_req_out, dmem_we_out, stall_out, load_valid_out, st_done_out, misaligned_out, bus_err_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out, load_data_out;
  logic [3:0]  dmem_mask_out;
  logic [4:0]  rd_addr_out;
  int checks = 0, errors = 0;

  always #5 clk_in = ~clk_in;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .ld_en_in(ld_en_in), .st_en_in(st_en_in),
    .addr_in(addr_in), .st_data_in(st_data_in), .load_size_in(load_size_in),
    .load_unsigned_in(load_unsigned_in), .rd_addr_in(rd_addr_in),
    .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out), .dmem_addr_out(dmem_addr_out),
    .dmem_wdata_out(dmem_wdata_out), .dmem_mask_out(dmem_mask_out),
    .dmem_ready_in(dmem_ready_in), .dmem_rdata_in(dmem_rdata_in), .stall_out(stall_out),
    .load_valid_out(load_valid_out), .load_data_out(load_data_out), .rd_addr_out(rd_addr_out),
    .st_done_out(st_done_out), .misaligned_out(misaligned_out), .bus_err_out(bus_err_out)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] sd, input logic [4:0] rd);
    ld_en_in = ld; st_en_in = st; addr_in = a; load_size_in = sz;
    load_unsigned_in = u; st_data_in = sd; rd_addr_in = rd;
  endtask

  task automatic test_reset;
    @(negedge clk_in);
    checks++;
    if ({dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_mask_out, stall_out,
         load_valid_out, load_data_out, rd_addr_out, st_done_out, misaligned_out, bus_err_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h mask=%b stall=%b lv=%b ld=%h rd=%0d sd=%b mis=%b err=%b, required all 0",
               dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_mask_out, stall_out,
               load_valid_out, load_data_out, rd_addr_out, st_done_out, misaligned_out, bus_err_out);
    end
    @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  // issue an aligned load with immediate ready and check the full 2-cycle timing
  task automatic test_load(input string nm, input logic [31:0] a, input logic [1:0] sz, input logic u,
                           input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] exp);
    tick;
    dmem_ready_in = 1; dmem_rdata_in = rdata;
    drive(1, 0, a, sz, u, 32'h0, rd);
    @(negedge clk_in);
    checks++;
    if (stall_out !== 1'b1 || dmem_req_out !== 1'b0) begin
      errors++; $display("FAIL %s_req_cycle: stall=%b req=%b, required stall=1 req=0", nm, stall_out, dmem_req_out);
    end
    tick;
    drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 5'd0);
    @(negedge clk_in);
    checks++;
    if (stall_out !== 1'b1 || dmem_req_out !== 1'b1 || dmem_we_out !== 1'b0 ||
        dmem_addr_out !== {a[31:2], 2'b00} || dmem_mask_out !== 4'b0000) begin
      errors++;
      $display("FAIL %s_busy: stall=%b req=%b we=%b addr=%h mask=%b, required 1 1 0 %h 0000",
               nm, stall_out, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_mask_out, {a[31:2], 2'b00});
    end
    tick;
    dmem_ready_in = 0;
    @(negedge clk_in);
    checks++;
    if (load_valid_out !== 1'b1 || load_data_out !== exp || rd_addr_out !== rd || stall_out !== 1'b0 || dmem_req_out !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: lv=%b data=%h rd=%0d stall=%b req=%b, required 1 %h %0d 0 0",
               nm, load_valid_out, load_data_out, rd_addr_out, stall_out, dmem_req_out, exp, rd);
    end
    tick;
    @(negedge clk_in);
    checks++;
    if (load_valid_out !== 1'b0) begin
      errors++; $display("FAIL %s_pulse: lv=%b, required 0", nm, load_valid_out);
    end
  endtask

  task automatic test_store(input string nm, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] sd,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_mask);
    tick;
    dmem_ready_in = 1;
    drive(0, 1, a, sz, 0, sd, 5'd0);
    tick;
    drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 5'd0);
    @(negedge clk_in);
    checks++;
    if (dmem_req_out !== 1'b1 || dmem_we_out !== 1'b1 || dmem_addr_out !== {a[31:2], 2'b00} ||
        dmem_wdata_out !== exp_wdata || dmem_mask_out !== exp_mask) begin
      errors++;
      $display("FAIL %s_bus: req=%b we=%b addr=%h wdata=%h mask=%b, required 1 1 %h %h %b",
               nm, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_mask_out,
               {a[31:2], 2'b00}, exp_wdata, exp_mask);
    end
    tick;
    dmem_ready_in = 0;
    @(negedge clk_in);
    checks++;
    if (st_done_out !== 1'b1 || dmem_req_out !== 1'b0 || load_valid_out !== 1'b0) begin
      errors++; $display("FAIL %s_done: st_done=%b req=%b lv=%b, required 1 0 0", nm, st_done_out, dmem_req_out, load_valid_out);
    end
    tick;
    @(negedge clk_in);
    checks++;
    if (st_done_out !== 1'b0) begin
      errors++; $display("FAIL %s_pulse: st_done=%b, required 0", nm, st_done_out);
    end
  endtask

  task automatic test_misaligned(input string nm, input logic ld, input logic [31:0] a, input logic [1:0] sz);
    logic saw_stall = 0, saw_req = 0;
    tick;
    dmem_ready_in = 1;
    drive(ld, ~ld, a, sz, 0, 32'hFFFF_FFFF, 5'd3);
    @(negedge clk_in);
    saw_stall = stall_out; saw_req = dmem_req_out;
    tick;
    drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 5'd0);
    @(negedge clk_in);
    saw_stall |= stall_out; saw_req |= dmem_req_out;
    checks++;
    if (misaligned_out !== 1'b1) begin
      errors++; $display("FAIL %s_flag: misaligned=%b, required 1", nm, misaligned_out);
    end
    tick;
    @(negedge clk_in);
    saw_stall |= stall_out; saw_req |= dmem_req_out;
    checks++;
    if (misaligned_out !== 1'b0 || saw_stall !== 1'b0 || saw_req !== 1'b0 || st_done_out !== 1'b0 || load_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL %s_quiet: misaligned=%b stall_seen=%b req_seen=%b st_done=%b lv=%b, required all 0",
               nm, misaligned_out, saw_stall, saw_req, st_done_out, load_valid_out);
    end
    dmem_ready_in = 0;
  endtask

  task automatic test_both_and_hold;
    tick;
    dmem_ready_in = 1; dmem_rdata_in = 32'h1122_3344;
    drive(1, 1, 32'h0000_0600, 2'b10, 0, 32'hDEAD_DEAD, 5'd7);
    tick;
    @(negedge clk_in);
    checks++;
    if (dmem_req_out !== 1'b1 || dmem_we_out !== 1'b0 || dmem_mask_out !== 4'b0000) begin
      errors++; $display("FAIL both_load_wins: req=%b we=%b mask=%b, required 1 0 0000", dmem_req_out, dmem_we_out, dmem_mask_out);
    end
    tick;
    @(negedge clk_in);
    checks++;
    if (load_valid_out !== 1'b1 || load_data_out !== 32'h1122_3344 || stall_out !== 1'b0) begin
      errors++; $display("FAIL done_ignores_req: lv=%b data=%h stall=%b, required 1 11223344 0", load_valid_out, load_data_out, stall_out);
    end
    tick;
    @(negedge clk_in);
    checks++;
    if (dmem_req_out !== 1'b0 || stall_out !== 1'b1 || load_valid_out !== 1'b0) begin
      errors++; $display("FAIL idle_after_done: req=%b stall=%b lv=%b, required 0 1 0", dmem_req_out, stall_out, load_valid_out);
    end
    drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 5'd0);
    tick; tick; tick;
    dmem_ready_in = 0;
  endtask

  task automatic test_reset_mid;
    logic saw_req = 0, saw_done = 0;
    tick;
    dmem_ready_in = 0;
    drive(0, 1, 32'h0000_0208, 2'b10, 0, 32'hCAFE_F00D, 5'd0);
    tick;
    drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 5'd0);
    tick; tick;
    checks++;
    if (dmem_req_out !== 1'b1 || dmem_wdata_out !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rst_mid_pre: req=%b wdata=%h, required 1 cafef00d", dmem_req_out, dmem_wdata_out);
    end
    reset_in = 1;
    #1;
    checks++;
    if ({dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_mask_out, stall_out,
         load_valid_out, st_done_out, misaligned_out, bus_err_out} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: req=%b we=%b addr=%h wdata=%h mask=%b stall=%b, required all 0",
               dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_mask_out, stall_out);
    end
    @(negedge clk_in);
    reset_in = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) dmem_ready_in = 1;
      @(negedge clk_in);
      saw_req |= dmem_req_out; saw_done |= st_done_out;
    end
    checks++;
    if (saw_req !== 1'b0 || saw_done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle: req_seen=%b st_done_seen=%b, required 0 0", saw_req, saw_done);
    end
    dmem_ready_in = 0;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    int busy_cycles = 0;
    logic saw_err = 0, saw_lv = 0;
    tick;
    dmem_ready_in = 0;
    drive(1, 0, 32'h0000_0500, 2'b10, 0, 32'h0, 5'd4);
    tick;
    drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 5'd0);
    for (int i = 0; i < 12 && !saw_err; i++) begin
      @(negedge clk_in);
      if (dmem_req_out) busy_cycles++;
      saw_err |= bus_err_out; saw_lv |= load_valid_out;
    end
    checks++;
    if (saw_err !== 1'b1 || busy_cycles != 4 || saw_lv !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: err_seen=%b busy_cycles=%0d lv_seen=%b, required 1 4 0", saw_err, busy_cycles, saw_lv);
    end
    @(negedge clk_in);
    checks++;
    if (bus_err_out !== 1'b0 || dmem_req_out !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse: err=%b req=%b, required 0 0", bus_err_out, dmem_req_out);
    end
    busy_cycles = 0; saw_err = 0; saw_lv = 0;
    tick;
    dmem_rdata_in = 32'h0BAD_F00D;
    drive(1, 0, 32'h0000_0504, 2'b10, 0, 32'h0, 5'd6);
    tick;
    drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 5'd0);
    for (int i = 0; i < 12 && !saw_lv && !saw_err; i++) begin
      @(negedge clk_in);
      if (dmem_req_out) busy_cycles++;
      if (busy_cycles == 4) dmem_ready_in = 1;
      saw_err |= bus_err_out; saw_lv |= load_valid_out;
    end
    dmem_ready_in = 0;
    checks++;
    if (saw_lv !== 1'b1 || saw_err !== 1'b0 || load_data_out !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL timeout_last_cycle: lv_seen=%b err_seen=%b data=%h, required 1 0 0badf00d", saw_lv, saw_err, load_data_out);
    end
  endtask
`else
  task automatic test_long_wait;
    int busy_cycles = 0;
    logic saw_err = 0, saw_done = 0;
    tick;
    dmem_ready_in = 0;
    drive(0, 1, 32'h0000_0700, 2'b10, 0, 32'h5555_AAAA, 5'd0);
    tick;
    drive(0, 0, 32'h0, 2'b00, 0, 32'h0, 5'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (dmem_req_out) busy_cycles++;
      saw_err |= bus_err_out;
    end
    checks++;
    if (busy_cycles != 20 || saw_err !== 1'b0) begin
      errors++; $display("FAIL long_wait_hold: busy_cycles=%0d err_seen=%b, required 20 0", busy_cycles, saw_err);
    end
    dmem_ready_in = 1;
    for (int i = 0; i < 4 && !saw_done; i++) begin
      @(negedge clk_in);
      saw_done |= st_done_out;
    end
    dmem_ready_in = 0;
    checks++;
    if (saw_done !== 1'b1) begin
      errors++; $display("FAIL long_wait_done: st_done_seen=%b, required 1", saw_done);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_load("lb", 32'h0000_0103, 2'b00, 0, 32'h80AA_BBCC, 5'd5, 32'hFFFF_FF80);
    test_load("lhu", 32'h0000_0102, 2'b01, 1, 32'h8001_1234, 5'd9, 32'h0000_8001);
    test_load("lbu", 32'h0000_0101, 2'b00, 1, 32'h80AA_BBCC, 5'd1, 32'h0000_00BB);
    test_load("lh", 32'h0000_0100, 2'b01, 0, 32'h80AA_BBCC, 5'd2, 32'hFFFF_BBCC);
    test_load("lw", 32'h0000_0104, 2'b10, 1, 32'hDEAD_BEEF, 5'd31, 32'hDEAD_BEEF);
    test_store("sb", 32'h0000_0201, 2'b00, 32'h1234_5678, 32'h7878_7878, 4'b0010);
    test_store("sh", 32'h0000_0302, 2'b01, 32'hAABB_CCDD, 32'hCCDD_CCDD, 4'b1100);
    test_store("sw", 32'h0000_0400, 2'b11, 32'h0102_0304, 32'h0102_0304, 4'b1111);
    test_misaligned("lw_mis", 1, 32'h0000_0106, 2'b10);
    test_misaligned("sh_mis", 0, 32'h0000_0301, 2'b01);
    test_both_and_hold;
    test_reset_mid;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`else
    test_long_wait;
`endif
    test_load("lb_after", 32'h0000_0003, 2'b00, 1, 32'h7F00_0000, 5'd12, 32'h0000_007F);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Stage-3 memory access block; consumes the ID/EX pipeline register outputs (iadder as effective address, rs2 as store data, load_size, load_unsigned, rd_addr).
- Drives a valid/ready data-memory port.
- Stalls the pipeline for the duration of each transaction.
- Returns aligned, sign- or zero-extended load data to the writeback mux.
- Flags misaligned accesses without issuing a bus transaction.

Parameters:
TIMEOUT_CYCLES, 16, bus wait limit in cycles; used only with LSU_TIMEOUT_EN.

Ports:
clk_in  input  1  clock
reset_in  input  1  reset, asynchronous, active-high
ld_en_in  input  1  load request from stage-2 register
st_en_in  input  1  store request from stage-2 register
addr_in  input  32  effective address (iadder)
st_data_in  input  32  store data (rs2)
load_size_in  input  2  00 byte, 01 half, 10/11 word
load_unsigned_in  input  1  1 = zero-extend, 0 = sign-extend
rd_addr_in  input  5  load destination register
dmem_req_out  output  1  bus request valid
dmem_we_out  output  1  1 = write
dmem_addr_out  output  32  word-aligned address ({addr[31:2],2'b00})
dmem_wdata_out  output  32  lane-replicated store data
dmem_mask_out  output  4  byte write strobes
dmem_ready_in  input  1  bus accept/response
dmem_rdata_in  input  32  read data, valid when ready
stall_out  output  1  hold upstream pipeline
load_valid_out  output  1  one-cycle pulse, load data valid
load_data_out  output  32  extended load result
rd_addr_out  output  5  destination register, qualified by load_valid_out
st_done_out  output  1  one-cycle pulse, store accepted
misaligned_out  output  1  one-cycle pulse, misaligned access
bus_err_out  output  1  one-cycle pulse, bus timeout

Behaviour:
Reset values:
- All outputs 0.
- FSM in IDLE.
- Internal address/data/size/rd registers 0.

FSM states and transitions:
- IDLE: samples a request when ld_en_in or st_en_in is high.
  - If both are high, the load wins and the store is dropped.
  - Misalignment check:
    - Half access with addr[0]=1 is misaligned.
    - Word access with addr[1:0]!=0 is misaligned.
    - Byte access is never misaligned.
  - Misaligned request: misaligned_out pulses the next cycle; no bus activity; stays in IDLE; stall_out not asserted.
  - Aligned request: latches addr/data/size/unsigned/rd, moves to BUSY.
- BUSY: dmem_req_out=1, with dmem_we_out, dmem_addr_out, dmem_wdata_out and dmem_mask_out held stable from the latched values.
  - On dmem_ready_in=1:
    - Load: capture dmem_rdata_in, go to DONE.
    - Store: pulse st_done_out the next cycle, go to IDLE.
  - dmem_req_out drops in the cycle after ready.
- DONE: load_valid_out=1 for exactly one cycle, with load_data_out and rd_addr_out; then IDLE.

Stall:
- stall_out = (IDLE and aligned request present) or BUSY (combinational).
- stall_out is deasserted in DONE.
- Minimum load latency: request cycle → BUSY (≥1 cycle) → DONE, so data is valid 2 cycles after the request when ready is high immediately.

Store data and masks:
- Byte: wdata = {4{st[7:0]}}, mask = 0001<<addr[1:0].
- Half: wdata = {2{st[15:0]}}, mask = 0011<<{addr[1],1'b0}.
- Word: wdata = st, mask = 1111.
- Loads drive mask 0000.

Load extraction:
- Byte lane selected by addr[1:0].
- Half lane selected by addr[1].
- Extension to 32 bits per load_unsigned; word loads are unaffected by load_unsigned.

Boundary rules:
- Requests arriving during BUSY or DONE are ignored; upstream is held by stall_out.
- Reset mid-transaction: immediate abandonment; dmem_req_out drops asynchronously.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a cycle counter runs in BUSY and clears on entry.
  - If dmem_ready_in has not been seen after TIMEOUT_CYCLES cycles in BUSY, drop the request, pulse bus_err_out for one cycle, return to IDLE.
  - No load_valid_out or st_done_out is produced for the aborted access.
  - Ready arriving on the final cycle counts as success.
- Undefined: no counter; bus_err_out tied to 0; BUSY waits indefinitely.

Decomposition:
- Package lsu_pkg:
  - load size encodings (LS_BYTE, LS_HALF, LS_WORD)
  - FSM state encoding (IDLE, BUSY, DONE)
  - XLEN=32
- Sub-module load_align: combinational lane select plus sign/zero extension (rdata, addr[1:0], size, unsigned → 32-bit result), instantiated once.

Test Plan:
- LB, addr 0x103, rdata 0x80AABBCC, ready on first BUSY cycle → load_data 0xFFFFFF80, load_valid pulses 2 cycles after request, stall high 2 cycles.
- LHU, addr 0x102, rdata 0x8001_1234 → load_data 0x00008001, rd_addr_out equals the rd_addr_in captured at request.
- SB, addr 0x201, st_data 0x12345678 → dmem_addr 0x200, mask 0010, wdata 0x78787878, st_done pulses once.
- LW, addr 0x106 → misaligned_out pulses; dmem_req_out stays 0; stall_out never asserted.
- Store with ready delayed 5 cycles, reset_in pulsed on cycle 3 → dmem_req_out drops immediately, all outputs 0, FSM in IDLE, no st_done.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4 and ready held low → bus_err_out pulses after 4 BUSY cycles; no load_valid_out; next request is serviced normally.
